// File: rtl/relm_uart_pkg.sv
// rtl/relm_uart_pkg.sv - shared encodings for the relm UART FIFO
// Holds RX/TX state encodings, parity codes, pop_q bit positions and a parity helper.
package relm_uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int POS_OVR  = 10;
  localparam int POS_PERR = 9;
  localparam int POS_FERR = 8;

  // The two FIFO status flags sit at the top of pop_q, so they move with WD.
  function automatic int pos_rxempty(input int wd);
    return wd;
  endfunction

  function automatic int pos_txfull(input int wd);
    return wd - 1;
  endfunction

  // Parity bit to put on the line: even parity makes the total count of ones even.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/relm_uart_sfifo.sv
// rtl/relm_uart_sfifo.sv - show-ahead synchronous FIFO
// Ports: clk, rst_n (async, active low), wr_en/wr_data write side (ignored when full),
//        rd_en pops the head (ignored when empty), rd_data is the current head, empty, full.
module relm_uart_sfifo #(
  parameter int WAD = 4,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);
  localparam int DEPTH = 1 << WAD;

  logic [W-1:0]   mem_q [DEPTH];
  logic [WAD-1:0] wr_ptr_q, wr_ptr_d;
  logic [WAD-1:0] rd_ptr_q, rd_ptr_d;
  logic [WAD:0]   count_q, count_d;
  logic           do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (WAD+1)'(DEPTH));
  // Both decisions use the occupancy at the start of the cycle, so a write
  // while full is dropped even if a pop happens in the same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + WAD'(do_wr);
    rd_ptr_d = rd_ptr_q + WAD'(do_rd);
    count_d  = count_q + (WAD+1)'(do_wr) - (WAD+1)'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/relm_uart_fifo.sv
// rtl/relm_uart_fifo.sv - UART with 16-deep TX and RX FIFOs behind a push/pop word interface
// Ports: clk, rst_n_in (async, active low), uart_in/uart_out serial lines (idle high),
//        push_d[WD] write strobe + [7:0] TX byte, push_retry = TX FIFO full,
//        pop_d[WD] RX pop strobe, pop_d[WD-2] overrun clear,
//        pop_q = {rx empty, tx full, ..., overrun, perr, ferr, rx data}.
module relm_uart_fifo
  import relm_uart_pkg::*;
#(
  parameter int WD     = 32,
  parameter int WAD    = 4,
  parameter int DIV    = 27,
  parameter int PARITY = 0,
  parameter int STOP2  = 0
) (
  input  logic        clk,
  input  logic        rst_n_in,
  input  logic        uart_in,
  output logic        uart_out,
  input  logic [WD:0] push_d,
  output logic        push_retry,
  input  logic [WD:0] pop_d,
  output logic [WD:0] pop_q
);
  localparam int TCW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RXEMPTY = pos_rxempty(WD);
  localparam int TXFULL  = pos_txfull(WD);

  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic           tick;
  logic [1:0]     sync_q, sync_d;
  logic           rx_line;

  rx_state_e rx_state_q, rx_state_d;
  logic [3:0] rx_ph_q, rx_ph_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rx_perr_q, rx_perr_d;
  logic       ovr_q, ovr_d;
  logic       rx_sample, rx_wr;
  logic [9:0] rx_wdata, rx_head;
  logic       rx_empty, rx_full;

  tx_state_e tx_state_q, tx_state_d;
  logic [3:0] tx_ph_q, tx_ph_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       tx_par_q, tx_par_d;
  logic       tx_loaded_q, tx_loaded_d;
  logic       tx_out_q, tx_out_d;
  logic       tx_bit_end, tx_rd;
  logic [7:0] tx_head;
  logic       tx_empty, tx_full;

  logic       unused_bits;
  assign unused_bits = ^{push_d[WD-1:8], pop_d[WD-1], pop_d[WD-3:0]};

  assign tick      = (tick_cnt_q == TCW'(DIV - 1));
  assign rx_line   = sync_q[1];
  // Phase 7 of 16 is mid-bit; the phase keeps counting so later samples land 16 ticks apart.
  assign rx_sample = tick && (rx_ph_q == 4'd7);
  assign tx_bit_end = tick && (tx_ph_q == 4'd15);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
    sync_d     = {sync_q[0], uart_in};
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_ph_d    = tick ? rx_ph_q + 4'd1 : rx_ph_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_perr_d  = rx_perr_q;
    rx_wr      = 1'b0;
    rx_wdata   = {rx_perr_q, !rx_line, rx_sh_q};
    case (rx_state_q)
      RX_IDLE: if (!rx_line) begin
        rx_state_d = RX_START;
        rx_ph_d    = '0;
        rx_perr_d  = 1'b0;
      end
      RX_START: if (rx_sample) begin
        rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        rx_bit_d   = '0;
      end
      RX_DATA: if (rx_sample) begin
        rx_sh_d  = {rx_line, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = (PARITY != PARITY_NONE) ? RX_PAR : RX_STOP;
      end
      RX_PAR: if (rx_sample) begin
        rx_perr_d  = (rx_line != parity_bit(rx_sh_q, PARITY));
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_sample) begin
        rx_wr      = 1'b1;
        rx_state_d = rx_line ? RX_IDLE : RX_BRK;
      end
      RX_BRK: if (rx_line) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
    // A drop caused by a full FIFO outranks a same-cycle clear.
    ovr_d = (rx_wr && rx_full) ? 1'b1 : (pop_d[WD-2] ? 1'b0 : ovr_q);
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_ph_d     = tick ? tx_ph_q + 4'd1 : tx_ph_q;
    tx_bit_d    = tx_bit_q;
    tx_sh_d     = tx_sh_q;
    tx_par_d    = tx_par_q;
    tx_loaded_d = tx_loaded_q;
    tx_rd       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_loaded_q) begin
          if (tick) begin
            tx_state_d  = TX_START;
            tx_ph_d     = '0;
            tx_loaded_d = 1'b0;
          end
        end else if (!tx_empty) begin
          tx_rd       = 1'b1;
          tx_sh_d     = tx_head;
          tx_par_d    = parity_bit(tx_head, PARITY);
          tx_loaded_d = 1'b1;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = (PARITY != PARITY_NONE) ? TX_PAR : TX_STOP;
      end
      TX_PAR: if (tx_bit_end) begin
        tx_state_d = TX_STOP;
        tx_bit_d   = '0;
      end
      TX_STOP: if (tx_bit_end) begin
        if (STOP2 != 0 && tx_bit_q == 3'd0) begin
          tx_bit_d = 3'd1;
        end else if (!tx_empty) begin
          // Chain straight into the next start bit so frames run back to back.
          tx_rd      = 1'b1;
          tx_sh_d    = tx_head;
          tx_par_d   = parity_bit(tx_head, PARITY);
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START: tx_out_d = 1'b0;
      TX_DATA:  tx_out_d = tx_sh_d[0];
      TX_PAR:   tx_out_d = tx_par_d;
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_cnt_q  <= '0;
      sync_q      <= 2'b11;
      rx_state_q  <= RX_IDLE;
      rx_ph_q     <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_perr_q   <= 1'b0;
      ovr_q       <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_ph_q     <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      tx_par_q    <= 1'b0;
      tx_loaded_q <= 1'b0;
      tx_out_q    <= 1'b1;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      sync_q      <= sync_d;
      rx_state_q  <= rx_state_d;
      rx_ph_q     <= rx_ph_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_perr_q   <= rx_perr_d;
      ovr_q       <= ovr_d;
      tx_state_q  <= tx_state_d;
      tx_ph_q     <= tx_ph_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_par_q    <= tx_par_d;
      tx_loaded_q <= tx_loaded_d;
      tx_out_q    <= tx_out_d;
    end
  end

  relm_uart_sfifo #(.WAD(WAD), .W(8)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n_in),
    .wr_en   (push_d[WD]),
    .wr_data (push_d[7:0]),
    .rd_en   (tx_rd),
    .rd_data (tx_head),
    .empty   (tx_empty),
    .full    (tx_full)
  );

  relm_uart_sfifo #(.WAD(WAD), .W(10)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n_in),
    .wr_en   (rx_wr),
    .wr_data (rx_wdata),
    .rd_en   (pop_d[WD]),
    .rd_data (rx_head),
    .empty   (rx_empty),
    .full    (rx_full)
  );

  assign uart_out   = tx_out_q;
  assign push_retry = tx_full;

  // Entry bits are masked while empty so stale storage never shows on the bus.
  always_comb begin
    pop_q          = '0;
    pop_q[RXEMPTY] = rx_empty;
    pop_q[TXFULL]  = tx_full;
    pop_q[POS_OVR] = ovr_q;
    if (!rx_empty) pop_q[POS_PERR:0] = rx_head;
  end

endmodule

// File: tb/tb_relm_uart_fifo.sv
// tb/tb_relm_uart_fifo.sv - self-checking bench for relm_uart_fifo
module tb_relm_uart_fifo;
  localparam int WD = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rx_a, out_a, retry_a;
  logic rst_b, drv_b, loop_b, rx_b, out_b, retry_b;
  logic [WD:0] push_a, pop_a, popq_a, push_b, pop_b, popq_b;

  assign rx_b = loop_b ? out_b : drv_b;

  relm_uart_fifo #(.WD(WD), .WAD(4), .DIV(2), .PARITY(0), .STOP2(0)) dut_a (
    .clk(clk), .rst_n_in(rst_a), .uart_in(rx_a), .uart_out(out_a),
    .push_d(push_a), .push_retry(retry_a), .pop_d(pop_a), .pop_q(popq_a)
  );

  relm_uart_fifo #(.WD(WD), .WAD(4), .DIV(2), .PARITY(2), .STOP2(1)) dut_b (
    .clk(clk), .rst_n_in(rst_b), .uart_in(rx_b), .uart_out(out_b),
    .push_d(push_b), .push_retry(retry_b), .pop_d(pop_b), .pop_q(popq_b)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_line(input int which, input logic v, input int n);
    if (which == 0) rx_a = v; else drv_b = v;
    repeat (n) @(negedge clk);
  endtask

  // One serial frame at 32 clk per bit: start, 8 data LSB first, optional parity, one stop.
  task automatic send_frame(input int which, input logic [7:0] b, input int par_mode, input bit bad_par);
    drive_line(which, 1'b0, 32);
    for (int i = 0; i < 8; i++) drive_line(which, b[i], 32);
    if (par_mode != 0) begin
      logic p;
      p = ($countones(b) % 2) == 1;
      if (par_mode == 1) p = ~p;
      if (bad_par) p = ~p;
      drive_line(which, p, 32);
    end
    drive_line(which, 1'b1, 32);
  endtask

  task automatic pop_rx(input int which);
    if (which == 0) pop_a[WD] = 1'b1; else pop_b[WD] = 1'b1;
    @(negedge clk);
    pop_a[WD] = 1'b0;
    pop_b[WD] = 1'b0;
  endtask

  task automatic wait_rx(input int which, input int limit, input string tag);
    int n;
    n = 0;
    while (((which == 0) ? popq_a[WD] : popq_b[WD]) !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < limit), 64'd1);
  endtask

  task automatic tx_frame_check(input logic [7:0] b);
    int n;
    int t;
    push_a = {1'b1, 24'h0, b};
    @(negedge clk);
    push_a = '0;
    n = 0;
    while (out_a !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", 64'(n < 200), 64'd1);
    t = 0;
    for (int k = 0; k < 10; k++) begin
      logic e;
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      while (t < 32 * k + 1) begin @(negedge clk); t++; end
      check("tx_bit_head", out_a, e);
      while (t < 32 * k + 30) begin @(negedge clk); t++; end
      check("tx_bit_tail", out_a, e);
    end
    repeat (40) @(negedge clk);
    check("tx_idle_after", out_a, 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int lows;
    rst_a = 1'b0; rst_b = 1'b0;
    rx_a = 1'b1; drv_b = 1'b1; loop_b = 1'b1;
    push_a = '0; pop_a = '0; push_b = '0; pop_b = '0;
    repeat (3) @(negedge clk);
    check("rst_rxempty", popq_a[WD], 1'b1);
    check("rst_retry", retry_a, 1'b0);
    check("rst_uart_out", out_a, 1'b1);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_popq", popq_a, {1'b1, 32'h0});

    // TX framing
    tx_frame_check(8'h55);
    r = 8'($urandom);
    tx_frame_check(r);

    // Glitch shorter than half a bit is rejected and the receiver still works afterwards
    rx_a = 1'b0;
    repeat (8) @(negedge clk);
    rx_a = 1'b1;
    repeat (64) @(negedge clk);
    check("glitch_empty", popq_a[WD], 1'b1);
    r = 8'($urandom);
    send_frame(0, r, 0, 1'b0);
    check("post_glitch_data", popq_a[WD:0], {1'b0, 21'h0, 3'b000, r});
    pop_rx(0);
    check("post_glitch_empty", popq_a[WD], 1'b1);

    // Break: one framing-error entry, then nothing until the line returns high
    drive_line(0, 1'b0, 12 * 32);
    check("brk_entry", popq_a[WD:0], {1'b0, 21'h0, 11'h100});
    pop_rx(0);
    check("brk_empty_low", popq_a[WD], 1'b1);
    drive_line(0, 1'b0, 64);
    check("brk_still_empty", popq_a[WD], 1'b1);
    drive_line(0, 1'b1, 64);
    check("brk_release_empty", popq_a[WD], 1'b1);
    r = 8'($urandom);
    send_frame(0, r, 0, 1'b0);
    check("post_brk_data", popq_a[10:0], {3'b000, r});
    pop_rx(0);

    // Overrun: 17 frames, no pops
    exp_q.delete();
    for (int i = 0; i < 17; i++) begin
      r = 8'($urandom);
      if (i < 16) exp_q.push_back(r);
      send_frame(0, r, 0, 1'b0);
    end
    check("ovr_set", popq_a[10], 1'b1);
    pop_a[WD-2] = 1'b1;
    @(negedge clk);
    pop_a[WD-2] = 1'b0;
    check("ovr_cleared", popq_a[10], 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("ovr_nonempty", popq_a[WD], 1'b0);
      check("ovr_data", popq_a[9:0], {2'b00, exp_q[i]});
      pop_rx(0);
    end
    check("ovr_17th_absent", popq_a[WD], 1'b1);
    pop_rx(0);
    check("pop_when_empty", popq_a, {1'b1, 32'h0});

    // TX FIFO full: first byte moves to the shifter, so 16 more fill the FIFO
    for (int i = 0; i < 20; i++) begin
      push_a = {1'b1, 24'h0, (i == 0) ? 8'h00 : 8'($urandom)};
      @(negedge clk);
      check("tx_retry", retry_a, (i >= 16) ? 1'b1 : 1'b0);
    end
    push_a = '0;
    repeat (100) @(negedge clk);
    check("tx_midframe_low", out_a, 1'b0);
    rst_a = 1'b0;
    #1;
    check("rst_async_out", out_a, 1'b1);
    check("rst_async_retry", retry_a, 1'b0);
    check("rst_async_rxempty", popq_a[WD], 1'b1);
    @(negedge clk);
    rst_a = 1'b1;
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (out_a !== 1'b1) lows++;
    end
    check("tx_aborted_idle", 64'(lows), 64'd0);
    check("tx_aborted_retry", retry_a, 1'b0);

    // Loopback with even parity and two stop bits
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      r = (i == 0) ? 8'hA5 : 8'($urandom);
      exp_q.push_back(r);
      push_b = {1'b1, 24'h0, r};
      @(negedge clk);
    end
    push_b = '0;
    for (int i = 0; i < 4; i++) begin
      wait_rx(1, 1500, "lb_wait");
      check("lb_data", popq_b[10:0], {3'b000, exp_q[i]});
      pop_rx(1);
    end
    check("lb_empty_after_pop", popq_b[WD], 1'b1);

    // Parity error injection on the even-parity instance
    repeat (64) @(negedge clk);
    drv_b = 1'b1;
    loop_b = 1'b0;
    r = 8'($urandom);
    send_frame(1, r, 2, 1'b1);
    wait_rx(1, 100, "perr_wait");
    check("perr_entry", popq_b[10:0], {3'b010, r});
    pop_rx(1);
    r = 8'($urandom);
    send_frame(1, r, 2, 1'b0);
    wait_rx(1, 100, "par_ok_wait");
    check("par_ok_entry", popq_b[10:0], {3'b000, r});
    pop_rx(1);
    check("par_empty", popq_b[WD], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
